// File: rtl/ccsds123_frame_ctrl.sv
// rtl/ccsds123_frame_ctrl.sv - input-side frame controller for the CCSDS-123 compressor
// Packs one-sample beats into PIPELINES-wide vectors and bounds the number of images in flight.
module ccsds123_frame_ctrl #(
    parameter int PIPELINES    = 4,
    parameter int D            = 16,
    parameter int NX           = 16,
    parameter int NY           = 16,
    parameter int NZ           = 8,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic [D-1:0]           s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [PIPELINES*D-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    input  logic                   c_out_tvalid,
    input  logic                   c_out_tlast,
    output logic [3:0]             inflight,
    output logic                   frame_done,
    output logic [15:0]            frames_out,
    output logic                   busy,
    output logic                   err_underflow
);

    localparam int unsigned NSAMP = NX * NY * NZ;
    localparam int unsigned SW    = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int unsigned LW    = (PIPELINES > 1) ? $clog2(PIPELINES) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(NSAMP - 1);
    localparam logic [LW-1:0] L_LAST = LW'(PIPELINES - 1);
    localparam logic [3:0]    MAX_IF = 4'(MAX_INFLIGHT);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          l_q, l_d;
    logic [SW-1:0]          s_q, s_d;
    logic [PIPELINES*D-1:0] v_q, v_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [3:0]             inflight_q, inflight_d;
    logic                   frame_done_q, frame_done_d;
    logic [15:0]            frames_out_q, frames_out_d;
    logic                   err_q, err_d;

    logic gate;
    logic accept;
    logic admit;
    logic complete;

    // Admission is judged against the registered inflight count, never the in-cycle update.
    assign gate     = (state_q == ST_ACTIVE) || (enable && (inflight_q < MAX_IF));
    assign s_tready = aresetn && gate && (!m_tvalid_q || m_tready);
    assign accept   = s_tvalid && s_tready;
    assign admit    = accept && (state_q == ST_IDLE);
    assign complete = c_out_tvalid && c_out_tlast;

    always_comb begin
        state_d      = state_q;
        l_d          = l_q;
        s_d          = s_q;
        v_d          = v_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        inflight_d   = inflight_q;
        err_d        = err_q;
        frame_done_d = complete;
        frames_out_d = frames_out_q + {15'd0, complete};

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end

        if (accept) begin
            for (int i = 0; i < PIPELINES; i++) begin
                if (l_q == LW'(i)) begin
                    v_d[i*D +: D] = s_tdata;
                end
            end
            if (s_q == S_LAST) begin
                s_d     = '0;
                state_d = ST_IDLE;
            end else begin
                s_d     = s_q + 1'b1;
                state_d = ST_ACTIVE;
            end
            // A freshly completed vector overrides the clear of the one taken this cycle.
            if (l_q == L_LAST) begin
                m_tvalid_d = 1'b1;
                m_tlast_d  = (s_q == S_LAST);
                l_d        = '0;
            end else begin
                l_d = l_q + 1'b1;
            end
        end

        if (complete && (inflight_q == 4'd0)) begin
            err_d = 1'b1;
        end
        if (admit && !complete) begin
            inflight_d = inflight_q + 4'd1;
        end else if (complete && !admit && (inflight_q != 4'd0)) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            l_q          <= '0;
            s_q          <= '0;
            v_q          <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            inflight_q   <= 4'd0;
            frame_done_q <= 1'b0;
            frames_out_q <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            l_q          <= l_d;
            s_q          <= s_d;
            v_q          <= v_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            inflight_q   <= inflight_d;
            frame_done_q <= frame_done_d;
            frames_out_q <= frames_out_d;
            err_q        <= err_d;
        end
    end

    assign m_tdata       = v_q;
    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign inflight      = inflight_q;
    assign frame_done    = frame_done_q;
    assign frames_out    = frames_out_q;
    assign err_underflow = err_q;
    assign busy          = (inflight_q != 4'd0) || (s_q != '0) || m_tvalid_q;

endmodule
